cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- FSM controller sequencing the 2-way set-associative, write-back cache datapath. The datapath contains the data, valid, dirty, tag and LRU arrays.
- Accepts CPU read/write requests and evaluates hit/miss from datapath status.
- Drives array load enables, mux selects and physical-memory handshakes for writeback and allocate.
- Keeps hit/miss/writeback performance counters.
- Sits between the CPU-side memory port and the pmem port, alongside cache_datapath inside the cache top.

Parameters:
CNT_W, 32, width of each performance counter (saturating).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
pmem_read  out  1  line-fill request to physical memory
pmem_write  out  1  line-writeback request to physical memory
pmem_resp  in  1  physical memory completion pulse
hit  in  1  datapath: some way valid and tag-equal
hit_way  in  1  datapath: matching way
lru_way  in  1  datapath: LRU (victim) way of indexed set
victim_valid  in  1  valid bit of lru_way in indexed set
victim_dirty  in  1  dirty bit of lru_way in indexed set
way_sel  out  1  way addressed by array writes / writeback read
load_data  out  1  write enable, data array
data_sel  out  1  0 = CPU write-merge, 1 = pmem line
load_tag  out  1  write enable, tag array
load_valid  out  1  write enable, valid array (valid_in = 1)
load_dirty  out  1  write enable, dirty array
dirty_in  out  1  value written to dirty array
load_lru  out  1  write enable, LRU array
lru_in  out  1  new LRU way for indexed set
pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, index, 0}
hit_count  out  CNT_W  completed hits
miss_count  out  CNT_W  misses detected
wb_count  out  CNT_W  dirty writebacks completed

Behaviour:
- Reset (rst low, async): state IDLE, victim register 0, counters 0. All 1-bit outputs 0 immediately, including a pmem_read/pmem_write in flight. Mid-op reset abandons the transaction; pmem must tolerate a dropped request.
- Outside the listed assertions, every output is 0. way_sel defaults to the registered victim.
- IDLE:
  - mem_read|mem_write -> COMPARE. Arrays read the index this cycle.
  - Both asserted: treat as write.
- COMPARE, hit:
  - mem_resp=1; load_lru=1, lru_in=~hit_way; way_sel=hit_way.
  - Write hit: additionally load_data=1, data_sel=0, load_dirty=1, dirty_in=1.
  - hit_count++ unless the hit follows an ALLOCATE.
  - -> IDLE.
- COMPARE, miss:
  - Register victim<=lru_way; miss_count++.
  - victim_valid&victim_dirty -> WRITEBACK, else -> ALLOCATE.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim, held until pmem_resp.
  - On pmem_resp: wb_count++, -> ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, held until pmem_resp.
  - On pmem_resp, same cycle: load_data=1, data_sel=1, load_tag=1, load_valid=1, load_dirty=1, dirty_in=0, way_sel=victim.
  - -> COMPARE. The re-lookup hits; a write merges there.
- Latency: hit = 2 cycles request-to-mem_resp. Clean miss = 3 + fill latency. Dirty miss adds writeback latency.
- mem_resp is never asserted outside COMPARE and is exactly one cycle per request.
- CPU contract: request and address stable until mem_resp. If the request drops mid-miss, the controller still completes the pmem transaction, then returns through COMPARE → IDLE without mem_resp (hit=don't-care, request low).
- Counters saturate at 2^CNT_W-1, no wrap.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.

Decomposition:
- cache_pkg: state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE), way_t, DATA_SEL_CPU/DATA_SEL_PMEM, ADDR_SEL_CPU/ADDR_SEL_VICTIM constants. Shared with cache_datapath.
- Sub-module cache_perf_cnt: one saturating CNT_W counter with inc input, instantiated three times.

Test Plan:
- Read hit: line valid in way 1; mem_read=1 -> mem_resp on cycle 2, load_lru=1, lru_in=0, no pmem traffic, hit_count=1.
- Write hit: way 0 hit -> load_data=1, data_sel=0, dirty_in=1, way_sel=0 with mem_resp; lru_in=1.
- Clean read miss: victim_valid=0, lru_way=1 -> pmem_read held through 5 waiting cycles. On pmem_resp: load_tag/valid/data=1, dirty_in=0, way_sel=1. Next cycle hit -> mem_resp; miss_count=1, hit_count=0.
- Dirty write miss: victim_dirty=1, lru_way=0 -> pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read, then COMPARE write-merge with dirty_in=1; wb_count=1.
- Reset mid-ALLOCATE: drop rst while pmem_read=1 -> pmem_read and all enables 0 same cycle. After release, state IDLE and counters 0.
- Saturation: CNT_W=4, 17 read hits -> hit_count=15.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared controller/datapath types and mux-select encodings
package cache_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  typedef logic way_t;
  localparam logic DATA_SEL_CPU    = 1'b0;
  localparam logic DATA_SEL_PMEM   = 1'b1;
  localparam logic ADDR_SEL_CPU    = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;
endpackage

// File: rtl/cache_perf_cnt.sv
// cache_perf_cnt: saturating event counter
module cache_perf_cnt #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count up on inc, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/cache_control.sv
// cache_control: FSM sequencing the 2-way write-back cache datapath and pmem port
module cache_control import cache_pkg::*; #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             hit,
  input  logic             hit_way,
  input  logic             lru_way,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  output logic             way_sel,
  output logic             load_data,
  output logic             data_sel,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             lru_in,
  output logic             pmem_addr_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);
  state_t state, next;
  way_t victim;
  logic from_alloc, req, hit_inc, miss_inc, wb_inc;
  assign req = mem_read | mem_write;
  // state register, victim capture on miss, and a flag marking the post-fill re-lookup
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      victim     <= '0;
      from_alloc <= 1'b0;
    end else begin
      state      <= next;
      from_alloc <= state == ALLOCATE;
      if (state == COMPARE && req && !hit) victim <= lru_way;
    end
  // next state and datapath/pmem controls; a dropped request after a fill returns silently
  always_comb begin
    next          = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = victim;
    load_data     = 1'b0;
    data_sel      = DATA_SEL_CPU;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    pmem_addr_sel = ADDR_SEL_CPU;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    case (state)
      IDLE: next = req ? COMPARE : IDLE;
      COMPARE:
        if (!req) next = IDLE;
        else if (hit) begin
          next       = IDLE;
          mem_resp   = 1'b1;
          load_lru   = 1'b1;
          lru_in     = ~hit_way;
          way_sel    = hit_way;
          load_data  = mem_write;
          load_dirty = mem_write;
          dirty_in   = mem_write;
          hit_inc    = !from_alloc;
        end else begin
          miss_inc = 1'b1;
          next     = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
        end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = ADDR_SEL_VICTIM;
        wb_inc        = pmem_resp;
        next          = pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        pmem_read  = 1'b1;
        load_data  = pmem_resp;
        data_sel   = pmem_resp ? DATA_SEL_PMEM : DATA_SEL_CPU;
        load_tag   = pmem_resp;
        load_valid = pmem_resp;
        load_dirty = pmem_resp;
        next       = pmem_resp ? COMPARE : ALLOCATE;
      end
      default: next = IDLE;
    endcase
  end
  cache_perf_cnt #(.CNT_W(CNT_W)) u_hit  (.clk(clk), .rst(rst), .inc(hit_inc),  .count(hit_count));
  cache_perf_cnt #(.CNT_W(CNT_W)) u_miss (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count));
  cache_perf_cnt #(.CNT_W(CNT_W)) u_wb   (.clk(clk), .rst(rst), .inc(wb_inc),   .count(wb_count));
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized scoreboard bench for the cache controller
module tb_cache_control;
  localparam int CNT_W = 4;
  localparam int MAXC = 15;
  logic clk = 0, rst = 0;
  logic mem_read = 0, mem_write = 0, pmem_resp = 0, hit = 0, hit_way = 0, lru_way = 0;
  logic victim_valid = 0, victim_dirty = 0;
  logic mem_resp, pmem_read, pmem_write, way_sel, load_data, data_sel, load_tag, load_valid;
  logic load_dirty, dirty_in, load_lru, lru_in, pmem_addr_sel;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;
  int pass_n = 0, total_n = 0, cyc = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  logic exp_victim = 0;
  typedef struct {logic wr; logic way; int lat; int start; int hc; int mc; int wc;} resp_t;
  resp_t resp_q[$];
  logic fill_q[$];

  cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit(hit),
    .hit_way(hit_way), .lru_way(lru_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .way_sel(way_sel), .load_data(load_data), .data_sel(data_sel), .load_tag(load_tag),
    .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru),
    .lru_in(lru_in), .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, int act, int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int sat(int v);
    return v < MAXC ? v + 1 : v;
  endfunction

  // kind: 0 hit, 1 clean miss, 2 dirty miss; fl/wl = cycles pmem takes to respond
  task automatic do_req(input logic wr, input logic rd, input int kind, input logic way,
                        input int fl, input int wl, input logic abandon);
    int rc, wc, n;
    logic filled, done;
    resp_t it;
    rc = 0; wc = 0; n = 0; filled = 0; done = 0;
    if (kind == 0) m_hit = sat(m_hit);
    else m_miss = sat(m_miss);
    if (kind == 2) m_wb = sat(m_wb);
    it.wr = wr; it.way = way; it.start = cyc;
    it.lat = 2 + (kind > 0 ? fl + 1 : 0) + (kind == 2 ? wl : 0);
    it.hc = m_hit; it.mc = m_miss; it.wc = m_wb;
    if (!abandon) resp_q.push_back(it);
    if (kind > 0) begin fill_q.push_back(way); exp_victim = way; end
    mem_read = rd; mem_write = wr;
    hit = kind == 0;
    hit_way = kind == 0 ? way : 1'($urandom);
    lru_way = kind == 0 ? 1'($urandom) : way;
    if (kind == 2) begin victim_valid = 1; victim_dirty = 1; end
    else if (kind == 1) begin
      victim_valid = $urandom_range(0, 1) == 1;
      victim_dirty = victim_valid ? 1'b0 : 1'($urandom);
    end else begin victim_valid = 1'($urandom); victim_dirty = 1'($urandom); end
    while (!done && n < 300) begin
      @(posedge clk); #1; n++;
      pmem_resp = 0;
      if (mem_resp) done = 1;
      else if (pmem_write) begin wc++; pmem_resp = wc == wl; end
      else if (pmem_read) begin
        rc++;
        pmem_resp = rc == fl;
        if (abandon && rc == 1) begin mem_read = 0; mem_write = 0; end
        if (pmem_resp) begin filled = 1; hit = 1; hit_way = way; done = abandon; end
      end
    end
    chk("req_done", done, 1);
    @(posedge clk); #1;
    pmem_resp = 0; mem_read = 0; mem_write = 0;
    if (abandon) begin @(posedge clk); #1; end
  endtask

  // response scoreboard: every mem_resp must match the oldest outstanding request
  initial forever begin
    resp_t it;
    @(negedge clk);
    if (mem_resp) begin
      if (resp_q.size() == 0) chk("unexpected_resp", mem_resp, 0);
      else begin
        it = resp_q.pop_front();
        chk("resp_way_sel", way_sel, it.way);
        chk("resp_lru_in", lru_in, !it.way);
        chk("resp_load_lru", load_lru, 1);
        chk("resp_load_data", load_data, it.wr);
        chk("resp_load_dirty", load_dirty, it.wr);
        chk("resp_dirty_in", dirty_in, it.wr);
        if (it.wr) chk("resp_data_sel", data_sel, 0);
        chk("resp_no_tag", {load_tag, load_valid}, 0);
        chk("resp_no_pmem", {pmem_read, pmem_write}, 0);
        chk("resp_latency", cyc - it.start + 1, it.lat);
        @(negedge clk);
        chk("hit_count", hit_count, it.hc);
        chk("miss_count", miss_count, it.mc);
        chk("wb_count", wb_count, it.wc);
        chk("resp_one_cycle", mem_resp, 0);
      end
    end
  end

  // fill and writeback monitor
  initial forever begin
    logic w;
    @(negedge clk);
    if (load_tag) begin
      if (fill_q.size() == 0) chk("unexpected_fill", load_tag, 0);
      else begin
        w = fill_q.pop_front();
        chk("fill_way_sel", way_sel, w);
        chk("fill_data_sel", data_sel, 1);
        chk("fill_loads", {load_data, load_valid, load_dirty}, 7);
        chk("fill_dirty_in", dirty_in, 0);
        chk("fill_pmem_read", pmem_read, 1);
        chk("fill_addr_sel", pmem_addr_sel, 0);
        chk("fill_no_resp", mem_resp, 0);
      end
    end
    if (pmem_write) begin
      chk("wb_addr_sel", pmem_addr_sel, 1);
      chk("wb_way_sel", way_sel, exp_victim);
      chk("wb_no_read", pmem_read, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int kind, fl, wl, n;
    logic wr, rd, ab;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_resp, pmem_read, pmem_write, way_sel, load_data, data_sel, load_tag,
        load_valid, load_dirty, dirty_in, load_lru, lru_in, pmem_addr_sel}, 0);
    chk("reset_counts", {hit_count, miss_count, wb_count}, 0);
    rst = 1;
    @(posedge clk); #1;
    do_req(0, 1, 0, 1, 1, 1, 0);
    do_req(1, 0, 0, 0, 1, 1, 0);
    do_req(0, 1, 1, 1, 6, 1, 0);
    do_req(1, 0, 2, 0, 3, 4, 0);
    do_req(1, 1, 0, 1, 1, 1, 0);
    repeat (150) begin
      kind = int'($urandom_range(0, 2));
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      fl = int'($urandom_range(1, 6));
      wl = int'($urandom_range(1, 5));
      ab = kind > 0 && $urandom_range(0, 7) == 0;
      do_req(wr, rd, kind, 1'($urandom), fl, wl, ab);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("resp_q_drained", resp_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    mem_read = 1; hit = 0; victim_valid = 0; victim_dirty = 0; lru_way = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!pmem_read && n < 10);
    chk("alloc_reached", pmem_read, 1);
    #2 rst = 0;
    #1;
    chk("rst_pmem", {pmem_read, pmem_write}, 0);
    chk("rst_enables", {mem_resp, load_data, load_tag, load_valid, load_dirty, load_lru}, 0);
    mem_read = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("rst_counts", {hit_count, miss_count, wb_count}, 0);
    m_hit = 0; m_miss = 0; m_wb = 0;
    repeat (17) do_req(0, 1, 0, 1'($urandom), 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hit_count", hit_count, 15);
    chk("final_miss_count", miss_count, m_miss);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
